// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared timing defaults, FSM states and pixel width for the WS2812 frame controller
package ws2812_pkg;
  localparam int PIX_W     = 24;
  localparam int BIT_CYC   = 20;
  localparam int T0H_CYC   = 6;
  localparam int T1H_CYC   = 13;
  localparam int LATCH_CYC = 1000;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;
endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// ws2812_frame_ctrl_if: pixel valid/ready handshake between a pixel source and the frame controller
interface ws2812_frame_ctrl_if;
  import ws2812_pkg::*;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  modport master(output pix_data, pix_valid, input pix_ready);
  modport slave(input pix_data, pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: per-bit cycle counter and registered WS2812 high/low compare for Dout
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYC,
  parameter int T0H_CYCLES = T0H_CYC,
  parameter int T1H_CYCLES = T1H_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_bit,
  output logic o_bit_last,
  output logic o_dout
);
  localparam int CW = $clog2(BIT_CYCLES);
  logic [CW-1:0] r_bit_cnt;
  logic          r_dout;
  logic          w_high;
  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $error("ws2812_bit_encoder: timing must satisfy 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end
  assign o_bit_last = i_en && r_bit_cnt == CW'(BIT_CYCLES - 1);
  assign w_high     = i_en && r_bit_cnt < (i_bit ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES));
  assign o_dout     = r_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_dout    <= 1'b0;
    end else begin
      r_bit_cnt <= (!i_en || o_bit_last) ? '0 : r_bit_cnt + 1'b1;
      r_dout    <= w_high;
    end
  end
endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: fetches GRB pixels over valid/ready and sequences a full WS2812 frame onto Dout
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = BIT_CYC,
  parameter int T0H_CYCLES   = T0H_CYC,
  parameter int T1H_CYCLES   = T1H_CYC,
  parameter int LATCH_CYCLES = LATCH_CYC
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  ws2812_frame_ctrl_if.slave pix,
  output logic               Dout,
  output logic               busy,
  output logic               done,
  output logic               underrun
);
  localparam int FW = $clog2(NUM_LEDS + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int BW = $clog2(PIX_W);
  state_t           r_state, w_state_nxt;
  logic [PIX_W-1:0] r_shift, r_buf;
  logic [FW-1:0]    r_fetch_cnt, r_led_idx, w_fetch_nxt;
  logic [BW-1:0]    r_bit_idx;
  logic [LW-1:0]    r_latch_cnt;
  logic r_buf_full, r_ready, r_busy, r_done, r_underrun;
  logic w_hs, w_bit_last, w_pix_end, w_last_led, w_drain, w_underrun, w_buf_full_nxt, w_ready_nxt;
  if (NUM_LEDS < 1 || NUM_LEDS > 1024) begin : g_bad_num
    $error("ws2812_frame_ctrl: NUM_LEDS must be in 1..1024");
  end
  ws2812_bit_encoder #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES)
  ) u_enc (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .i_en      (r_state == SHIFT),
    .i_bit     (r_shift[PIX_W-1]),
    .o_bit_last(w_bit_last),
    .o_dout    (Dout)
  );
  assign w_hs           = pix.pix_valid && r_ready;
  assign w_pix_end      = w_bit_last && r_bit_idx == BW'(PIX_W - 1);
  assign w_last_led     = r_led_idx == FW'(NUM_LEDS - 1);
  assign w_drain        = r_state == SHIFT && w_pix_end && !w_last_led && r_buf_full;
  assign w_underrun     = r_state == SHIFT && w_pix_end && !w_last_led && !r_buf_full;
  assign w_buf_full_nxt = w_drain ? 1'b0 : (w_hs && r_state == SHIFT) || r_buf_full;
  assign w_fetch_nxt    = (r_state == IDLE && start) ? '0 : w_hs ? r_fetch_cnt + 1'b1 : r_fetch_cnt;
  assign w_ready_nxt    = (w_state_nxt == FETCH || w_state_nxt == SHIFT) && !w_buf_full_nxt &&
                          w_fetch_nxt < FW'(NUM_LEDS);
  assign pix.pix_ready  = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign underrun       = r_underrun;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start ? FETCH : IDLE;
      FETCH:   w_state_nxt = w_hs ? SHIFT : FETCH;
      SHIFT:   w_state_nxt = (w_pix_end && (w_last_led || !r_buf_full)) ? LATCH : SHIFT;
      LATCH:   w_state_nxt = (r_latch_cnt == LW'(LATCH_CYCLES)) ? IDLE : LATCH;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_state_nxt != IDLE;
      r_done     <= r_state == LATCH && w_state_nxt == IDLE;
      r_underrun <= w_underrun;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_shift     <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_fetch_cnt <= '0;
      r_led_idx   <= '0;
      r_bit_idx   <= '0;
      r_latch_cnt <= '0;
    end else begin
      r_shift     <= (w_hs && r_state == FETCH) ? pix.pix_data :
                     w_drain ? r_buf : w_bit_last ? r_shift << 1 : r_shift;
      r_buf       <= (w_hs && r_state == SHIFT) ? pix.pix_data : r_buf;
      r_buf_full  <= w_buf_full_nxt;
      r_fetch_cnt <= w_fetch_nxt;
      r_led_idx   <= (r_state == IDLE && start) ? '0 : w_pix_end ? r_led_idx + 1'b1 : r_led_idx;
      r_bit_idx   <= (r_state != SHIFT || w_pix_end) ? '0 : w_bit_last ? r_bit_idx + 1'b1 : r_bit_idx;
      r_latch_cnt <= (r_state == LATCH && w_state_nxt == LATCH) ? r_latch_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: directed self-checking bench for the WS2812 frame controller
module tb_ws2812_frame_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0, valid = 1'b0, sel = 1'b0;
  logic [23:0] data = '0;
  logic        a_start, a_dout, a_busy, a_done, a_under;
  logic        b_start, b_dout, b_busy, b_done, b_under;
  logic        dout, ready, busy, done, under;
  int          errs = 0, checks = 0;
  int          hs_n, hs1, hs2, und_n, und_at, done_n, done_at, bad_n, first_bad, busy_bad;
  logic        pre_dout, post_dout, post_busy, post_ready;

  always #5 sys_clk = ~sys_clk;

  ws2812_frame_ctrl_if a_if ();
  ws2812_frame_ctrl_if b_if ();

  ws2812_frame_ctrl #(.NUM_LEDS(1)) u_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(a_start), .pix(a_if),
    .Dout(a_dout), .busy(a_busy), .done(a_done), .underrun(a_under)
  );
  ws2812_frame_ctrl #(.NUM_LEDS(2)) u_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(b_start), .pix(b_if),
    .Dout(b_dout), .busy(b_busy), .done(b_done), .underrun(b_under)
  );

  assign a_start        = start && !sel;
  assign b_start        = start && sel;
  assign a_if.pix_data  = data;
  assign b_if.pix_data  = data;
  assign a_if.pix_valid = valid && !sel;
  assign b_if.pix_valid = valid && sel;
  assign dout  = sel ? b_dout : a_dout;
  assign ready = sel ? b_if.pix_ready : a_if.pix_ready;
  assign busy  = sel ? b_busy : a_busy;
  assign done  = sel ? b_done : a_done;
  assign under = sel ? b_under : a_under;

  // Runs one frame from a start pulse; t counts edges after the start edge, observed at negedges.
  task automatic frame(input logic [23:0] p0, p1, input int nleds, n_give, extra_at, rst_at, input bit b2b);
    logic [23:0] pix [2];
    int   nbits, k, idx;
    logic exp_d, bv;
    pix[0] = p0;
    pix[1] = p1;
    nbits = 24 * (n_give < nleds ? n_give : nleds);
    hs_n = 0; hs1 = -1; hs2 = -1; und_n = 0; und_at = -1;
    done_n = 0; done_at = -1; bad_n = 0; first_bad = -1; busy_bad = 0;
    start = 1'b1;
    valid = 1'b0;
    for (int t = 0; t < 2200; t++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (rst_at >= 0 && t == rst_at + 1) begin
        post_dout = dout; post_busy = busy; post_ready = ready;
        sys_rst = 1'b0;
        break;
      end
      k = t - hs1;
      exp_d = 1'b0;
      if (hs1 >= 0 && k >= 1 && k <= nbits * 20) begin
        idx   = (k - 1) / 20;
        bv    = pix[idx / 24][23 - idx % 24];
        exp_d = ((k - 1) % 20) < (bv ? 13 : 6);
      end
      if (dout !== exp_d) begin bad_n++; if (first_bad < 0) first_bad = t; end
      if (under === 1'b1) begin und_n++; und_at = t; end
      if (done === 1'b1) begin done_n++; done_at = t; end
      if (busy !== (done_n == 0)) busy_bad++;
      if (t == rst_at) begin pre_dout = dout; sys_rst = 1'b1; end
      valid = hs_n < n_give;
      data  = pix[hs_n < 2 ? hs_n : 1];
      if (valid && ready === 1'b1 && !sys_rst) begin
        hs_n++;
        if (hs_n == 1) hs1 = t + 1; else hs2 = t + 1;
      end
      start = (t == extra_at) || (b2b && done_n > 0);
      if (b2b && done_n > 0) break;
      if (done_n > 0 && t >= done_at + 20) break;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(negedge sys_clk);
    checks++; if (a_dout !== 1'b0) begin errs++; $display("FAIL rst_a_dout: got %b expected 0", a_dout); end
    checks++; if (a_if.pix_ready !== 1'b0) begin errs++; $display("FAIL rst_a_ready: got %b expected 0", a_if.pix_ready); end
    checks++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rst_a_busy: got %b expected 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errs++; $display("FAIL rst_a_done: got %b expected 0", a_done); end
    checks++; if (a_under !== 1'b0) begin errs++; $display("FAIL rst_a_under: got %b expected 0", a_under); end
    checks++; if (b_dout !== 1'b0) begin errs++; $display("FAIL rst_b_dout: got %b expected 0", b_dout); end
    checks++; if (b_if.pix_ready !== 1'b0) begin errs++; $display("FAIL rst_b_ready: got %b expected 0", b_if.pix_ready); end
    checks++; if (b_busy !== 1'b0) begin errs++; $display("FAIL rst_b_busy: got %b expected 0", b_busy); end
    checks++; if (b_done !== 1'b0) begin errs++; $display("FAIL rst_b_done: got %b expected 0", b_done); end
    checks++; if (b_under !== 1'b0) begin errs++; $display("FAIL rst_b_under: got %b expected 0", b_under); end
    sys_rst = 1'b0;
  endtask

  task automatic test_single_pixel();
    sel = 1'b0;
    frame(24'h800000, 24'h800000, 1, 2, -1, -1, 0);
    checks++; if (hs_n !== 1) begin errs++; $display("FAIL single_accepts: got %0d expected 1", hs_n); end
    checks++; if (hs1 !== 1) begin errs++; $display("FAIL single_hs_at: got %0d expected 1", hs1); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL single_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (und_n !== 0) begin errs++; $display("FAIL single_underrun: got %0d expected 0", und_n); end
    checks++; if (done_n !== 1) begin errs++; $display("FAIL single_done_cnt: got %0d expected 1", done_n); end
    checks++; if (done_at !== 1482) begin errs++; $display("FAIL single_done_at: got %0d expected 1482", done_at); end
    checks++; if (busy_bad !== 0) begin errs++; $display("FAIL single_busy: %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_two_pixels();
    sel = 1'b1;
    frame(24'hFFFFFF, 24'h000000, 2, 2, -1, -1, 0);
    checks++; if (hs_n !== 2) begin errs++; $display("FAIL two_accepts: got %0d expected 2", hs_n); end
    checks++; if (hs2 !== 2) begin errs++; $display("FAIL two_second_hs_at: got %0d expected 2", hs2); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL two_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (und_n !== 0) begin errs++; $display("FAIL two_underrun: got %0d expected 0", und_n); end
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL two_done_at: got %0d expected 1962", done_at); end
    checks++; if (busy_bad !== 0) begin errs++; $display("FAIL two_busy: %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_underrun();
    sel = 1'b1;
    frame(24'h5A3C96, 24'h000000, 2, 1, -1, -1, 0);
    checks++; if (hs_n !== 1) begin errs++; $display("FAIL und_accepts: got %0d expected 1", hs_n); end
    checks++; if (und_n !== 1) begin errs++; $display("FAIL und_count: got %0d expected 1", und_n); end
    checks++; if (und_at !== 481) begin errs++; $display("FAIL und_at: got %0d expected 481", und_at); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL und_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (done_n !== 1) begin errs++; $display("FAIL und_done_cnt: got %0d expected 1", done_n); end
    checks++; if (done_at !== 1482) begin errs++; $display("FAIL und_done_at: got %0d expected 1482", done_at); end
  endtask

  task automatic test_start_ignored();
    sel = 1'b1;
    frame(24'h123456, 24'hFEDCBA, 2, 2, 500, -1, 0);
    checks++; if (hs_n !== 2) begin errs++; $display("FAIL ign_shift_accepts: got %0d expected 2", hs_n); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL ign_shift_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL ign_shift_done_at: got %0d expected 1962", done_at); end
    checks++; if (busy_bad !== 0) begin errs++; $display("FAIL ign_shift_busy: %0d bad cycles expected 0", busy_bad); end
    frame(24'h123456, 24'hFEDCBA, 2, 2, 1700, -1, 0);
    checks++; if (hs_n !== 2) begin errs++; $display("FAIL ign_latch_accepts: got %0d expected 2", hs_n); end
    checks++; if (done_n !== 1) begin errs++; $display("FAIL ign_latch_done_cnt: got %0d expected 1", done_n); end
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL ign_latch_done_at: got %0d expected 1962", done_at); end
    checks++; if (busy_bad !== 0) begin errs++; $display("FAIL ign_latch_busy: %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    frame(24'hFFFFFF, 24'hFFFFFF, 2, 2, -1, 104, 0);
    checks++; if (pre_dout !== 1'b1) begin errs++; $display("FAIL mid_pre_dout: got %b expected 1", pre_dout); end
    checks++; if (post_dout !== 1'b0) begin errs++; $display("FAIL mid_dout: got %b expected 0", post_dout); end
    checks++; if (post_busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b expected 0", post_busy); end
    checks++; if (post_ready !== 1'b0) begin errs++; $display("FAIL mid_ready: got %b expected 0", post_ready); end
    frame(24'h00FF00, 24'hFF00FF, 2, 2, -1, -1, 0);
    checks++; if (hs_n !== 2 || hs1 !== 1) begin errs++; $display("FAIL mid_after_hs: got %0d at %0d expected 2 at 1", hs_n, hs1); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL mid_after_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL mid_after_done_at: got %0d expected 1962", done_at); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    frame(24'hC0FFEE, 24'h0F0F0F, 2, 2, -1, -1, 1);
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL b2b_first_done_at: got %0d expected 1962", done_at); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL b2b_first_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    frame(24'hA5A5A5, 24'h3C3C3C, 2, 2, -1, -1, 0);
    checks++; if (hs1 !== 1 || hs2 !== 2) begin errs++; $display("FAIL b2b_second_hs: got %0d,%0d expected 1,2", hs1, hs2); end
    checks++; if (bad_n !== 0) begin errs++; $display("FAIL b2b_second_dout: %0d bad cycles (first t=%0d) expected 0", bad_n, first_bad); end
    checks++; if (done_at !== 1962) begin errs++; $display("FAIL b2b_second_done_at: got %0d expected 1962", done_at); end
    checks++; if (done_n !== 1) begin errs++; $display("FAIL b2b_second_done_cnt: got %0d expected 1", done_n); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_two_pixels();
    test_underrun();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
Frame-level sequencer for a WS2812b LED chain. It fetches 24-bit GRB pixel words from an upstream source over a valid/ready handshake. Each word is serialised MSB-first onto Dout using WS2812 high/low bit timing, back-to-back with no inter-bit gaps. After the last pixel it holds Dout low for the latch/reset interval and then reports done. It sits between the pixel source (frame buffer or pattern generator) and the Dout pad, and runs in the sys domain clocked from the on-chip oscillator (15.65 MHz nominal).

Parameters:
NUM_LEDS, 8, pixels per frame (1..1024)
BIT_CYCLES, 20, sys_clk cycles per bit, about 1.28 us
T0H_CYCLES, 6, high time for a 0 bit, about 0.38 us
T1H_CYCLES, 13, high time for a 1 bit, about 0.83 us
LATCH_CYCLES, 1000, low hold after the frame, about 64 us

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
start  in  1  one-cycle frame request
pix_data  in  24  pixel word: [23:16]=G, [15:8]=R, [7:0]=B
pix_valid  in  1  pix_data valid
pix_ready  out  1  controller accepts pix_data this cycle
Dout  out  1  serial line to the first LED
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of frame
underrun  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- All outputs are registered.
- Reset values: Dout=0, pix_ready=0, busy=0, done=0, underrun=0, state=IDLE, holding buffer empty, all counters 0.
- FSM states: IDLE, FETCH, SHIFT, LATCH.
- IDLE: Dout=0. When start=1, go to FETCH and clear fetch_cnt and led_idx. start is ignored in every other state.
- FETCH: wait for the first pixel. A handshake is pix_valid & pix_ready on the same edge.
  - On the handshake, load the shift register directly (bit 23 first) and set fetch_cnt=1.
  - Go to SHIFT. Dout rises on the next edge, so first Dout high is 1 cycle after the handshake.
- Prefetch rule: pix_ready=1 in FETCH/SHIFT iff the holding buffer is empty and fetch_cnt < NUM_LEDS.
  - In SHIFT, a handshake fills the one-entry holding buffer and increments fetch_cnt.
- SHIFT:
  - bit_cnt runs 0..BIT_CYCLES-1.
  - Dout=1 while bit_cnt < (bit ? T1H_CYCLES : T0H_CYCLES), else 0.
  - At bit_cnt=BIT_CYCLES-1, shift to the next bit.
  - After bit 0 of a pixel, led_idx++:
    - If led_idx was NUM_LEDS-1: go to LATCH.
    - Else if the buffer is full: move the buffer into the shift register, mark the buffer empty, and continue. The next bit starts on the following cycle with no gap.
    - Else (underrun): pulse underrun, force Dout=0, go to LATCH. Remaining pixels are not requested.
- LATCH: Dout=0 for exactly LATCH_CYCLES cycles, then go to IDLE and pulse done in the first IDLE cycle. done also follows an underrun abort.
- A handshake and a buffer drain on the same edge are impossible by construction, because ready is only high while the buffer is empty.
- Frame length in SHIFT is NUM_LEDS*24*BIT_CYCLES cycles when there is no underrun.
- Counter widths are clog2-sized. Counter comparisons are unsigned and never wrap.
- Parameters must satisfy 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES. Violations are a static elaboration error.
- sys_rst asserted mid-frame returns the block to reset values on the next edge. Dout drops to 0 immediately; no latch period is inserted.

Decomposition:
- Shared package ws2812_pkg holds:
  - default timing constants for the 15.65 MHz clock (BIT, T0H, T1H, LATCH)
  - the state enum {IDLE, FETCH, SHIFT, LATCH}
  - the pixel width constant 24
- One sub-module, ws2812_bit_encoder:
  - owns bit_cnt and the Dout compare
  - inputs: bit value, enable
  - output: bit_last strobe to the FSM
- The FSM, holding buffer and pixel counters stay in ws2812_frame_ctrl.

Test Plan:
- Single pixel, NUM_LEDS=1, pix_data=0x800000 always valid, start pulse -> 24 bits: bit 23 high for 13 cycles then low 7, then 23 bits each high 6 / low 14. Dout then low for 1000 cycles; done pulses once at cycle 1+480+1000 after the handshake.
- Two pixels 0xFFFFFF, 0x000000 with valid always high -> 48 periods of 20 cycles with no gap. pix_ready pulses twice, with the second accept occurring during pixel 0.
- Source withholds the second pixel, NUM_LEDS=2 -> underrun pulses after pixel 0's last bit, Dout stays low, done pulses after LATCH_CYCLES, fetch_cnt=1.
- start pulsed while busy -> ignored; frame length and done timing are unchanged; there is no second frame.
- sys_rst asserted in the middle of bit 5 -> next cycle Dout=0, busy=0, pix_ready=0. A following start runs a full correct frame.
- Back-to-back frames: start asserted on the done cycle -> second frame begins normally and its timing matches the first.
